// File: rtl/pd_tx_pkg.sv
// Shared types for the USB PD transmit protocol engine: state encoding,
// header bit positions and the header assembly helper.
package pd_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_PHY,
    ST_WAIT_GOODCRC,
    ST_SUCCESS,
    ST_FAIL,
    ST_DISCARD
  } tx_state_e;

  localparam int TYPE_LSB  = 0;
  localparam int DROLE     = 5;
  localparam int REV_LSB   = 6;
  localparam int PROLE     = 8;
  localparam int MSGID_LSB = 9;
  localparam int NDO_LSB   = 12;
  localparam int EXT       = 15;

  // mhi = MESSAGE_HEADER_INFO[3:0], tx1_hi = TX_BUF_HEADER_BYTE_1[7:4]
  function automatic logic [15:0] build_header(input logic [3:0] mhi,
                                               input logic [4:0] msg_type,
                                               input logic [3:0] tx1_hi,
                                               input logic [2:0] id);
    logic [15:0] h;
    h                   = '0;
    h[TYPE_LSB +: 5]    = msg_type;
    h[DROLE]            = mhi[3];
    h[REV_LSB +: 2]     = mhi[2:1];
    h[PROLE]            = mhi[0];
    h[MSGID_LSB +: 3]   = id;
    h[NDO_LSB +: 3]     = tx1_hi[2:0];
    h[EXT]              = tx1_hi[3];
    return h;
  endfunction

endpackage

// File: rtl/pd_tx_crc_timer.sv
// CRCReceiveTimer: clear/enable up-counter; expired flags the last cycle of
// the GoodCRC window (count == CRC_TIMEOUT-1).
module pd_tx_crc_timer #(
  parameter int CRC_TIMEOUT = 9
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int TW = $clog2(CRC_TIMEOUT + 1);

  logic [TW-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   count <= '0;
    else if (clr)   count <= '0;
    else if (en)    count <= count + 1'b1;
  end

  assign expired = (count == TW'(CRC_TIMEOUT - 1));

endmodule

// File: rtl/pd_tx_protocol.sv
// USB PD transmit protocol layer: header build, GoodCRC wait with retry,
// alert pulses and MessageIDCounter. Define PD_TX_MSGID_CHECK_EN to require
// the GoodCRC MessageID to match msg_id.
module pd_tx_protocol
  import pd_tx_pkg::*;
#(
  parameter int CRC_TIMEOUT = 9,
  parameter int RETRY_MAX   = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        hard_reset,
  input  logic        tx_start,
  input  logic [7:0]  MESSAGE_HEADER_INFO,
  input  logic [7:0]  TX_BUF_HEADER_BYTE_0,
  input  logic [7:0]  TX_BUF_HEADER_BYTE_1,
  input  logic        phy_tx_done,
  input  logic        phy_rx_goodcrc,
  input  logic [2:0]  rx_goodcrc_msgid,
  input  logic        rx_message_received,
  output logic        phy_tx_start,
  output logic [15:0] phy_tx_header,
  output logic        tx_success,
  output logic        tx_failed,
  output logic        tx_discarded,
  output logic [2:0]  msg_id,
  output logic        busy
);

  localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

  tx_state_e     state, state_nxt;
  logic [RW-1:0] retry_cnt;
  logic          crc_expired;
  logic          goodcrc_ok;
  logic          unused_in;

`ifdef PD_TX_MSGID_CHECK_EN
  assign goodcrc_ok = phy_rx_goodcrc && (rx_goodcrc_msgid == msg_id);
  assign unused_in  = ^{MESSAGE_HEADER_INFO[7:4], TX_BUF_HEADER_BYTE_0[7:5],
                        TX_BUF_HEADER_BYTE_1[3:0]};
`else
  assign goodcrc_ok = phy_rx_goodcrc;
  assign unused_in  = ^{MESSAGE_HEADER_INFO[7:4], TX_BUF_HEADER_BYTE_0[7:5],
                        TX_BUF_HEADER_BYTE_1[3:0], rx_goodcrc_msgid};
`endif

  pd_tx_crc_timer #(.CRC_TIMEOUT(CRC_TIMEOUT)) u_crc_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (hard_reset || (state != ST_WAIT_GOODCRC)),
    .en      (state == ST_WAIT_GOODCRC),
    .expired (crc_expired)
  );

  // Priority, lowest to highest: normal flow, GoodCRC, discard, hard_reset.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:         if (tx_start) state_nxt = ST_SEND;
      ST_SEND:         state_nxt = ST_WAIT_PHY;
      ST_WAIT_PHY:     if (phy_tx_done) state_nxt = ST_WAIT_GOODCRC;
      ST_WAIT_GOODCRC: begin
        if (goodcrc_ok)       state_nxt = ST_SUCCESS;
        else if (crc_expired) state_nxt = (retry_cnt < RW'(RETRY_MAX)) ? ST_SEND : ST_FAIL;
      end
      ST_SUCCESS,
      ST_FAIL,
      ST_DISCARD:      state_nxt = ST_IDLE;
      default:         state_nxt = ST_IDLE;
    endcase
    if (rx_message_received && (state inside {ST_SEND, ST_WAIT_PHY, ST_WAIT_GOODCRC}))
      state_nxt = ST_DISCARD;
    if (hard_reset)
      state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      msg_id        <= '0;
      retry_cnt     <= '0;
      phy_tx_header <= '0;
    end else begin
      state <= state_nxt;
      if (hard_reset) begin
        msg_id    <= '0;
        retry_cnt <= '0;
      end else begin
        // Retries re-latch with the unchanged msg_id, so the header is identical.
        if (state_nxt == ST_SEND)
          phy_tx_header <= build_header(MESSAGE_HEADER_INFO[3:0], TX_BUF_HEADER_BYTE_0[4:0],
                                        TX_BUF_HEADER_BYTE_1[7:4], msg_id);
        if (state == ST_WAIT_GOODCRC && state_nxt == ST_SEND)
          retry_cnt <= retry_cnt + 1'b1;
        if (state inside {ST_SUCCESS, ST_FAIL, ST_DISCARD}) begin
          msg_id    <= msg_id + 1'b1;
          retry_cnt <= '0;
        end
      end
    end
  end

  assign phy_tx_start = (state == ST_SEND);
  assign tx_success   = (state == ST_SUCCESS);
  assign tx_failed    = (state == ST_FAIL);
  assign tx_discarded = (state == ST_DISCARD);
  assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_pd_tx_protocol.sv
// Directed bench for pd_tx_protocol: a per-cycle expectation timeline built
// from the protocol timing rules, checked every cycle, plus literal pins.
module tb_pd_tx_protocol;

  localparam int N = 1024;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        hard_reset = 1'b0;
  logic        tx_start = 1'b0;
  logic        phy_tx_done = 1'b0;
  logic        phy_rx_goodcrc = 1'b0;
  logic        rx_message_received = 1'b0;
  logic [2:0]  rx_goodcrc_msgid = 3'd0;
  logic [7:0]  mhi = 8'd0, tx0 = 8'd0, tx1 = 8'd0;
  logic        phy_tx_start, tx_success, tx_failed, tx_discarded, busy;
  logic [15:0] phy_tx_header;
  logic [2:0]  msg_id;

  pd_tx_protocol #(.CRC_TIMEOUT(9), .RETRY_MAX(3)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .hard_reset           (hard_reset),
    .tx_start             (tx_start),
    .MESSAGE_HEADER_INFO  (mhi),
    .TX_BUF_HEADER_BYTE_0 (tx0),
    .TX_BUF_HEADER_BYTE_1 (tx1),
    .phy_tx_done          (phy_tx_done),
    .phy_rx_goodcrc       (phy_rx_goodcrc),
    .rx_goodcrc_msgid     (rx_goodcrc_msgid),
    .rx_message_received  (rx_message_received),
    .phy_tx_start         (phy_tx_start),
    .phy_tx_header        (phy_tx_header),
    .tx_success           (tx_success),
    .tx_failed            (tx_failed),
    .tx_discarded         (tx_discarded),
    .msg_id               (msg_id),
    .busy                 (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0, cyc = 0;
  bit chk_on = 1'b0;
  bit e_pts[N], e_succ[N], e_fail[N], e_disc[N], e_busy[N];
  int e_id[N], e_hdr[N];
  int model_id = 0;
  int n_pts = 0, n_succ = 0, n_fail = 0, n_disc = 0;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    vectors++;
    if (act !== 32'(exp)) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Header from field weights, independent of any bit-slice layout code.
  function automatic int hdr_of(input int id);
    return int'(tx1[7]) * 32768 + int'(tx1[6:4]) * 4096 + id * 512 +
           int'(mhi[0]) * 256 + int'(mhi[2:1]) * 64 + int'(mhi[3]) * 32 + int'(tx0[4:0]);
  endfunction

  always @(negedge clk) begin
    if (chk_on && cyc < N) begin
      check("phy_tx_start", phy_tx_start, int'(e_pts[cyc]));
      check("tx_success",   tx_success,   int'(e_succ[cyc]));
      check("tx_failed",    tx_failed,    int'(e_fail[cyc]));
      check("tx_discarded", tx_discarded, int'(e_disc[cyc]));
      check("busy",         busy,         int'(e_busy[cyc]));
      check("msg_id",       msg_id,       e_id[cyc]);
      if (e_busy[cyc]) check("phy_tx_header", phy_tx_header, e_hdr[cyc]);
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      n_pts  += int'(phy_tx_start);
      n_succ += int'(tx_success);
      n_fail += int'(tx_failed);
      n_disc += int'(tx_discarded);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic fill_busy(input int c, input bit v);
    for (int i = c; i < N; i++) e_busy[i] = v;
  endtask

  task automatic fill_id(input int c, input int v);
    for (int i = c; i < N; i++) e_id[i] = v;
  endtask

  task automatic exp_send(input int c);
    int h;
    h = hdr_of(model_id);
    e_pts[c] = 1'b1;
    for (int i = c; i < N; i++) e_hdr[i] = h;
  endtask

  // kind: 0 success, 1 failed, 2 discarded; alert in cycle a, idle from a+1.
  task automatic finish(input int a, input int kind);
    case (kind)
      0:       e_succ[a] = 1'b1;
      1:       e_fail[a] = 1'b1;
      default: e_disc[a] = 1'b1;
    endcase
    fill_busy(a + 1, 1'b0);
    model_id = (model_id + 1) % 8;
    fill_id(a + 1, model_id);
  endtask

  // Issue TRANSMIT; returns in the SEND cycle.
  task automatic start_tx();
    tx_start = 1'b1;
    exp_send(cyc + 1);
    fill_busy(cyc + 1, 1'b1);
    tick();
    tx_start = 1'b0;
  endtask

  // From SEND: wait `extra` cycles in WAIT_PHY, pulse phy_tx_done in cycle m.
  task automatic to_wait_crc(input int extra, output int m);
    tick();
    ticks(extra);
    phy_tx_done = 1'b1;
    m = cyc;
    tick();
    phy_tx_done = 1'b0;
  endtask

  task automatic ack();
    phy_rx_goodcrc   = 1'b1;
    rx_goodcrc_msgid = 3'(model_id);
    finish(cyc + 1, 0);
    tick();
    phy_rx_goodcrc = 1'b0;
    tick();
  endtask

  task automatic quick_ok();
    int m;
    start_tx();
    to_wait_crc(0, m);
    ack();
  endtask

  initial begin
    int m, p0, f0, d0, s0;
    #3;
    check("reset_busy",   busy, 0);
    check("reset_msg_id", msg_id, 0);
    check("reset_header", phy_tx_header, 0);
    check("reset_pulses", {phy_tx_start, tx_success, tx_failed, tx_discarded}, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk_on  = 1'b1;
    ticks(2);

    // Header build and success; tx_start while busy is ignored.
    mhi = 8'b00011010; tx0 = 8'b01001011; tx1 = 8'b00100111;
    start_tx();
    check("hdr_literal", phy_tx_header, 16'h206B);
    check("pts_literal", phy_tx_start, 1);
    tick();
    phy_tx_done = 1'b1; tx_start = 1'b1; m = cyc;
    tick();
    phy_tx_done = 1'b0; tx_start = 1'b0;
    tick();
    phy_rx_goodcrc = 1'b1; rx_goodcrc_msgid = 3'd0;
    finish(cyc + 1, 0);
    tick();
    phy_rx_goodcrc = 1'b0;
    check("success_literal", tx_success, 1);
    tick();
    check("msgid_after_ok", msg_id, 1);
    check("busy_after_ok", busy, 0);
    ticks(4);

    // Retry exhaustion with varying WAIT_PHY dwell.
    mhi = 8'h35; tx0 = 8'h1F; tx1 = 8'hF0;
    p0 = n_pts; f0 = n_fail;
    start_tx();
    for (int a = 0; a < 4; a++) begin
      to_wait_crc(a, m);
      if (a < 3) exp_send(m + 10);
      else       finish(m + 10, 1);
      while (cyc < m + 10) tick();
    end
    ticks(2);
    check("retry_pts_count", n_pts - p0, 4);
    check("retry_fail_count", n_fail - f0, 1);
    check("msgid_after_fail", msg_id, 2);

    // GoodCRC carrying the wrong MessageID.
    mhi = 8'h0C; tx0 = 8'h03; tx1 = 8'h10;
    start_tx();
    to_wait_crc(0, m);
    tick();
    phy_rx_goodcrc = 1'b1; rx_goodcrc_msgid = 3'(model_id ^ 5);
`ifdef PD_TX_MSGID_CHECK_EN
    exp_send(m + 10);
    tick();
    phy_rx_goodcrc = 1'b0;
    while (cyc < m + 10) tick();
    to_wait_crc(0, m);
    ack();
`else
    finish(cyc + 1, 0);
    tick();
    phy_rx_goodcrc = 1'b0;
    tick();
`endif
    check("msgid_after_idchk", msg_id, 3);

    // Discard during WAIT_PHY, then discard colliding with GoodCRC.
    d0 = n_disc; p0 = n_pts; s0 = n_succ;
    start_tx();
    tick();
    rx_message_received = 1'b1;
    finish(cyc + 1, 2);
    tick();
    rx_message_received = 1'b0;
    ticks(12);
    check("discard_count", n_disc - d0, 1);
    check("discard_no_resend", n_pts - p0, 1);
    check("msgid_after_disc", msg_id, 4);
    start_tx();
    to_wait_crc(0, m);
    rx_message_received = 1'b1; phy_rx_goodcrc = 1'b1; rx_goodcrc_msgid = 3'(model_id);
    finish(cyc + 1, 2);
    tick();
    rx_message_received = 1'b0; phy_rx_goodcrc = 1'b0;
    ticks(3);
    check("collide_no_success", n_succ - s0, 0);
    check("collide_discards", n_disc - d0, 2);
    check("msgid_after_collide", msg_id, 5);

    // Hard reset in IDLE, eight successes wrap msg_id, hard reset mid-wait.
    hard_reset = 1'b1;
    model_id = 0;
    fill_id(cyc + 1, 0);
    tick();
    hard_reset = 1'b0;
    tick();
    check("msgid_after_hr_idle", msg_id, 0);
    for (int i = 0; i < 8; i++) quick_ok();
    check("msgid_wrapped", msg_id, 0);
    quick_ok();
    start_tx();
    to_wait_crc(0, m);
    tick();
    hard_reset = 1'b1;
    model_id = 0;
    fill_busy(cyc + 1, 1'b0);
    fill_id(cyc + 1, 0);
    s0 = n_succ + n_fail + n_disc; p0 = n_pts;
    tick();
    hard_reset = 1'b0;
    check("hr_busy", busy, 0);
    check("hr_msg_id", msg_id, 0);
    ticks(12);
    check("hr_no_alert", n_succ + n_fail + n_disc - s0, 0);
    check("hr_no_retry", n_pts - p0, 0);

    // Asynchronous reset between edges in WAIT_GOODCRC.
    quick_ok();
    start_tx();
    to_wait_crc(0, m);
    chk_on = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("areset_busy",   busy, 0);
    check("areset_msg_id", msg_id, 0);
    check("areset_header", phy_tx_header, 0);
    check("areset_pulses", {phy_tx_start, tx_success, tx_failed, tx_discarded}, 0);
    model_id = 0;
    fill_busy(cyc, 1'b0);
    fill_id(cyc, 0);
    #2 reset_n = 1'b1;
    tick();
    chk_on = 1'b1;
    quick_ok();
    ticks(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pd_tx_protocol.md
# pd_tx_protocol

Transmit-side USB PD protocol-layer engine for the TCPC. It takes a TRANSMIT request, builds the 16-bit message header from MESSAGE_HEADER_INFO and the TX buffer header bytes, and hands it to the PHY. It then waits for the partner's GoodCRC and retries on timeout. It reports success, failure or discard as one-cycle alert pulses and owns the MessageIDCounter.

## Interface
- CRC_TIMEOUT, 9: clock cycles allowed for GoodCRC after phy_tx_done (CRCReceiveTimer).
- RETRY_MAX, 3: retransmissions after the first attempt (nRetryCount).
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- hard_reset  in  1  synchronous protocol Hard Reset; highest priority.
- tx_start  in  1  TRANSMIT request; sampled only in IDLE.
- MESSAGE_HEADER_INFO  in  8  [0] power role, [2:1] spec rev, [3] data role.
- TX_BUF_HEADER_BYTE_0  in  8  [4:0] message type.
- TX_BUF_HEADER_BYTE_1  in  8  [6:4] number of data objects, [7] extended.
- phy_tx_done  in  1  PHY finished sending current frame.
- phy_rx_goodcrc  in  1  GoodCRC received (1-cycle pulse).
- rx_goodcrc_msgid  in  3  MessageID carried by that GoodCRC.
- rx_message_received  in  1  non-GoodCRC message received (forces discard).
- phy_tx_start  out  1  1-cycle pulse: PHY sends phy_tx_header.
- phy_tx_header  out  16  assembled header; stable from phy_tx_start until IDLE.
- tx_success / tx_failed / tx_discarded  out  1 each  1-cycle alert pulses.
- msg_id  out  3  current MessageIDCounter.
- busy  out  1  high in any state except IDLE.

## Operation
- States: IDLE, SEND, WAIT_PHY, WAIT_GOODCRC, SUCCESS, FAIL, DISCARD.
- Header assembly: {TX1[7], TX1[6:4], msg_id, MHI[0], MHI[2:1], MHI[3], TX0[4:0]}, latched on entry to SEND.
- IDLE → SEND on tx_start. tx_start outside IDLE is ignored and not queued.
- SEND: assert phy_tx_start, then go to WAIT_PHY.
- WAIT_PHY → WAIT_GOODCRC on phy_tx_done. Timer clears to 0 on entry.
- WAIT_GOODCRC, each cycle:
  - A valid GoodCRC moves to SUCCESS.
  - Otherwise the timer increments.
  - When the timer reaches CRC_TIMEOUT-1: if retry_cnt < RETRY_MAX, increment retry_cnt and go to SEND with the same msg_id; otherwise go to FAIL.
- Valid GoodCRC: phy_rx_goodcrc high and, when PD_TX_MSGID_CHECK_EN is defined, rx_goodcrc_msgid == msg_id.
- Same-cycle GoodCRC and timeout: GoodCRC wins.
- rx_message_received in SEND, WAIT_PHY or WAIT_GOODCRC → DISCARD. Discard beats GoodCRC and beats timeout.
- SUCCESS, FAIL and DISCARD each pulse their alert and increment msg_id modulo 8 (7 → 0). They clear retry_cnt and timer, then go to IDLE.
- hard_reset, any state: go to IDLE; msg_id, retry_cnt and timer cleared; no alert pulse.
- Reset values: state IDLE, phy_tx_header 16'h0000, msg_id 0, retry_cnt 0, all pulses 0, busy 0.
- Width rules:
  - Timer width is $clog2(CRC_TIMEOUT+1).
  - retry_cnt width is $clog2(RETRY_MAX+1).
  - msg_id wraps naturally at 3 bits.

## Timing
- tx_start sampled high at edge k → phy_tx_start high from edge k+1 to k+2; busy high from k+1.
- phy_tx_done sampled at edge m → timer = 0 at m+1.
- GoodCRC sampled in WAIT_GOODCRC at edge n → tx_success high n+1 to n+2; msg_id updates at n+2; busy low from n+2.
- No GoodCRC after phy_tx_done: retry phy_tx_start pulse starts exactly CRC_TIMEOUT+1 cycles after the phy_tx_done sample.
- Total attempts: RETRY_MAX+1.
- phy_rx_goodcrc outside WAIT_GOODCRC is ignored.

## Configuration
- PD_TX_MSGID_CHECK_EN defined: GoodCRC accepted only when rx_goodcrc_msgid equals msg_id. A mismatched GoodCRC is ignored and the timer keeps running.
- Not defined: any phy_rx_goodcrc in WAIT_GOODCRC is accepted; rx_goodcrc_msgid is unused.

## Structure
- Package pd_tx_pkg holds:
  - State enum.
  - Header bit-position localparams (TYPE_LSB=0, DROLE=5, REV_LSB=6, PROLE=8, MSGID_LSB=9, NDO_LSB=12, EXT=15).
- Sub-module pd_tx_crc_timer: clear/enable counter with an expired output, parameterized by CRC_TIMEOUT.

## Test plan
- Header and success: MHI=8'b00011010, TX0=8'b01001011, TX1=8'b00100111, msg_id 0, tx_start, phy_tx_done, GoodCRC id 0 two cycles later → phy_tx_header=16'h206B, one tx_success pulse, msg_id=1.
- Retry exhaustion: RETRY_MAX=3, never send GoodCRC → 4 phy_tx_start pulses, each CRC_TIMEOUT+1 cycles after phy_tx_done, then one tx_failed pulse, msg_id +1.
- MessageID check (macro on): GoodCRC id 5 while msg_id=0 → ignored, retry occurs. Macro off: same stimulus → tx_success.
- Discard: rx_message_received during WAIT_PHY → tx_discarded pulse, no further phy_tx_start, msg_id +1. Repeat with GoodCRC in the same cycle as the discard → tx_discarded only.
- Wrap and hard reset: 8 consecutive successes → msg_id returns to 0. Then hard_reset mid-WAIT_GOODCRC → IDLE next cycle, no alert pulse, msg_id=0.
- Async reset: drop reset_n mid-transaction between clock edges → all outputs at reset values immediately; tx_start during busy is ignored.
